// File: rtl/pipe_operand_mux.sv
// rtl/pipe_operand_mux.sv - registered N-way EX-stage operand select with extended immediate
//
// Selects one of NUM_IN register-width sources or an extended immediate and
// captures it into a pipeline register with valid, stall and flush control.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    flattened sources, source k = in_data[k*WIDTH +: WIDTH]
//   imm        raw immediate field
//   sel        0..NUM_IN-1 picks a source, NUM_IN picks the extended immediate
//   imm_sign   1 = sign-extend imm, 0 = zero-extend
//   imm_hi     1 = imm in the upper bits, low bits zero (overrides imm_sign)
//   in_valid   upstream operand valid
//   stall      hold the pipeline register
//   flush      insert a bubble (wins over stall)
//   out_data   registered selected operand
//   out_valid  registered valid
//   out_sel    registered copy of sel
//   sel_err    sticky flag: a valid load used a select above NUM_IN
module pipe_operand_mux #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = $clog2(NUM_IN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [IMM_WIDTH-1:0]    imm,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    imm_sign,
  input  logic                    imm_hi,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
);

  logic [WIDTH-1:0] w_imm_zext;
  logic [WIDTH-1:0] w_imm_sext;
  logic [WIDTH-1:0] w_imm_high;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_nxt;
  logic             w_sel_imm;
  logic             w_sel_illegal;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic             r_err;

  // Size casts keep all three forms legal when IMM_WIDTH == WIDTH, where
  // each collapses to imm unchanged (shift amount becomes zero).
  assign w_imm_zext = WIDTH'(imm);
  assign w_imm_sext = WIDTH'($signed(imm));
  assign w_imm_high = w_imm_zext << (WIDTH - IMM_WIDTH);

  assign w_imm_ext = imm_hi   ? w_imm_high :
                     imm_sign ? w_imm_sext : w_imm_zext;

  assign w_sel_imm     = (sel == SEL_W'(NUM_IN));
  // Constant-false when NUM_IN+1 is a power of two; every code is then legal.
  assign w_sel_illegal = (sel >  SEL_W'(NUM_IN));

  always_comb begin
    w_nxt = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_nxt = in_data[k*WIDTH +: WIDTH];
      end
    end
    if (w_sel_imm) begin
      w_nxt = w_imm_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      // Bubble; the error flag is sticky and survives flushes.
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_sel   <= sel;
      // A bubble always carries zero data so stale operands never leak.
      r_data  <= in_valid ? w_nxt : '0;
      if (in_valid && w_sel_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
  assign sel_err   = r_err;

endmodule

// File: tb/tb_pipe_operand_mux.sv
// tb/tb_pipe_operand_mux.sv - self-checking bench for pipe_operand_mux
module tb_pipe_operand_mux;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic [15:0]  imm;
  logic [2:0]   sel;
  logic         imm_sign;
  logic         imm_hi;
  logic         in_valid;
  logic         stall;
  logic         flush;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [2:0]   out_sel;
  logic         sel_err;

  logic         s_rst;
  logic [7:0]   s_in_data;
  logic [7:0]   s_imm;
  logic [0:0]   s_sel;
  logic         s_imm_sign;
  logic         s_imm_hi;
  logic         s_in_valid;
  logic         s_stall;
  logic         s_flush;
  logic [7:0]   s_out_data;
  logic         s_out_valid;
  logic [0:0]   s_out_sel;
  logic         s_sel_err;

  int n_tests;
  int n_fail;

  logic [31:0] src [4];

  pipe_operand_mux u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .imm       (imm),
    .sel       (sel),
    .imm_sign  (imm_sign),
    .imm_hi    (imm_hi),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .sel_err   (sel_err)
  );

  pipe_operand_mux #(.WIDTH(8), .IMM_WIDTH(8), .NUM_IN(1)) u_small (
    .clk       (clk),
    .rst       (s_rst),
    .in_data   (s_in_data),
    .imm       (s_imm),
    .sel       (s_sel),
    .imm_sign  (s_imm_sign),
    .imm_hi    (s_imm_hi),
    .in_valid  (s_in_valid),
    .stall     (s_stall),
    .flush     (s_flush),
    .out_data  (s_out_data),
    .out_valid (s_out_valid),
    .out_sel   (s_out_sel),
    .sel_err   (s_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign in_data = {src[3], src[2], src[1], src[0]};

  typedef struct {
    logic        rst, flush, stall, vld;
    logic [2:0]  sel;
    logic [15:0] imm;
    logic        sgn, hi;
    logic [31:0] e_data;
    logic        e_valid;
    logic [2:0]  e_sel;
    logic        e_err;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic st, input logic v,
                     input logic [2:0] s, input logic [15:0] im, input logic sg,
                     input logic h, input logic [31:0] ed, input logic ev,
                     input logic [2:0] es, input logic ee);
    vec_t x;
    x.rst = r; x.flush = f; x.stall = st; x.vld = v; x.sel = s; x.imm = im;
    x.sgn = sg; x.hi = h; x.e_data = ed; x.e_valid = ev; x.e_sel = es; x.e_err = ee;
    vecs.push_back(x);
  endtask

  // Reference: operand value from the selection rules using plain arithmetic.
  function automatic logic [31:0] ref_nxt(input logic [2:0] s, input logic [15:0] im,
                                          input logic sg, input logic h);
    longint v;
    if (s < 3'd4) return src[s];
    if (s != 3'd4) return 32'h0;
    v = longint'(im);
    if (h) v = v * 65536;
    else if (sg && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  task automatic check_all(input string tag, input logic [31:0] ed, input logic ev,
                           input logic [2:0] es, input logic ee);
    check({tag, ".data"},  out_data,         ed);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, ".sel"},   {29'd0, out_sel},   {29'd0, es});
    check({tag, ".err"},   {31'd0, sel_err},   {31'd0, ee});
  endtask

  logic [31:0] m_data;
  logic        m_valid;
  logic [2:0]  m_sel;
  logic        m_err;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    src[0] = 32'h11111111; src[1] = 32'h22222222;
    src[2] = 32'h33333333; src[3] = 32'h44444444;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    sel = '0; imm = '0; imm_sign = 1'b0; imm_hi = 1'b0;
    s_rst = 1'b1; s_in_data = 8'h3C; s_imm = 8'hA5; s_sel = 1'b1;
    s_imm_sign = 1'b0; s_imm_hi = 1'b0; s_in_valid = 1'b0;
    s_stall = 1'b0; s_flush = 1'b0;

    //   rst fl st vld sel imm       sg hi  e_data        ev es  ee
    add(1, 0, 0, 0, 0, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);
    add(1, 0, 0, 1, 2, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);
    add(0, 0, 0, 1, 2, 16'h0000, 0, 0, 32'h33333333, 1, 2, 0);
    add(0, 0, 0, 1, 4, 16'h8001, 1, 0, 32'hFFFF8001, 1, 4, 0);
    add(0, 0, 0, 1, 4, 16'h8001, 0, 0, 32'h00008001, 1, 4, 0);
    add(0, 0, 0, 1, 4, 16'h8001, 1, 1, 32'h80010000, 1, 4, 0);
    add(0, 0, 0, 1, 1, 16'h0000, 0, 0, 32'h22222222, 1, 1, 0);
    add(0, 0, 1, 1, 3, 16'h0000, 0, 0, 32'h22222222, 1, 1, 0);
    add(0, 0, 1, 1, 3, 16'h0000, 0, 0, 32'h22222222, 1, 1, 0);
    add(0, 0, 1, 1, 3, 16'h0000, 0, 0, 32'h22222222, 1, 1, 0);
    add(0, 0, 0, 1, 3, 16'h0000, 0, 0, 32'h44444444, 1, 3, 0);
    add(0, 1, 1, 1, 0, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);
    add(0, 0, 0, 1, 5, 16'h0000, 0, 0, 32'h00000000, 1, 5, 1);
    add(0, 0, 0, 1, 0, 16'h0000, 0, 0, 32'h11111111, 1, 0, 1);
    add(0, 1, 0, 1, 0, 16'h0000, 0, 0, 32'h00000000, 0, 0, 1);
    add(1, 0, 0, 1, 0, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);
    add(0, 0, 0, 0, 5, 16'h0000, 0, 0, 32'h00000000, 0, 5, 0);
    add(0, 0, 0, 1, 3, 16'h0000, 0, 0, 32'h44444444, 1, 3, 0);
    add(1, 0, 1, 1, 3, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);
    add(0, 0, 1, 1, 2, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);
    add(0, 0, 0, 1, 2, 16'h0000, 0, 0, 32'h33333333, 1, 2, 0);
    add(0, 0, 1, 1, 5, 16'h0000, 0, 0, 32'h33333333, 1, 2, 0);
    add(0, 1, 0, 1, 5, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);
    add(1, 1, 0, 1, 6, 16'h0000, 0, 0, 32'h00000000, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush; stall = vecs[i].stall;
      in_valid = vecs[i].vld; sel = vecs[i].sel; imm = vecs[i].imm;
      imm_sign = vecs[i].sgn; imm_hi = vecs[i].hi;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                vecs[i].e_sel, vecs[i].e_err);
    end

    // Bubble with a live source value still carries zero data.
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
    src[0] = 32'hDEADBEEF; in_valid = 1'b1; sel = 3'd0;
    @(posedge clk); #1;
    check_all("bubble_pre", 32'hDEADBEEF, 1'b1, 3'd0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_all("bubble", 32'h0, 1'b0, 3'd0, 1'b0);

    // Narrow instance: IMM_WIDTH == WIDTH, every immediate mode passes imm.
    s_rst = 1'b0; s_in_valid = 1'b1; s_sel = 1'b1;
    for (int m = 0; m < 4; m++) begin
      s_imm_sign = m[0]; s_imm_hi = m[1];
      @(posedge clk); #1;
      check($sformatf("small_mode%0d", m), {24'd0, s_out_data}, 32'h000000A5);
    end
    check("small_valid", {31'd0, s_out_valid}, 32'd1);
    check("small_err",   {31'd0, s_sel_err},   32'd0);
    s_sel = 1'b0;
    @(posedge clk); #1;
    check("small_src0", {24'd0, s_out_data}, 32'h0000003C);

    // Randomized run against the reference model.
    rst = 1'b1;
    @(posedge clk); #1;
    m_data = '0; m_valid = 1'b0; m_sel = '0; m_err = 1'b0;
    for (int t = 0; t < 500; t++) begin
      rst      = ($urandom_range(0, 31) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      sel      = 3'($urandom_range(0, 7));
      imm      = 16'($urandom);
      imm_sign = 1'($urandom);
      imm_hi   = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      if (rst) begin
        m_data = '0; m_valid = 1'b0; m_sel = '0; m_err = 1'b0;
      end else if (flush) begin
        m_data = '0; m_valid = 1'b0; m_sel = '0;
      end else if (!stall) begin
        m_valid = in_valid;
        m_sel   = sel;
        m_data  = in_valid ? ref_nxt(sel, imm, imm_sign, imm_hi) : 32'h0;
        if (in_valid && sel > 3'd4) m_err = 1'b1;
      end
      @(posedge clk); #1;
      check_all($sformatf("rand%0d", t), m_data, m_valid, m_sel, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
